// File: rtl/board_status_pager_if.sv
// Board-side bundle for board_status_pager: phase array and raw board
// inputs toward the pager, 7-segment digits and LEDs back to the pins.
// master = top level / board driver, slave = the pager itself.
interface board_status_pager_if #(
    parameter int NUM_CHANNELS = 16
);
    logic [7:0] phases [0:NUM_CHANNELS-1];
    logic       read_error;
    logic       key_next_n;
    logic       key_clr_n;
    logic       scroll_hold;
    logic [6:0] hex [0:5];
    logic [9:0] ledr;

    modport master (
        output phases, read_error, key_next_n, key_clr_n, scroll_hold,
        input  hex, ledr
    );

    modport slave (
        input  phases, read_error, key_next_n, key_clr_n, scroll_hold,
        output hex, ledr
    );
endinterface

// File: rtl/board_status_pager.sv
// board_status_pager: pages NUM_CHANNELS 8-bit phases, three channels per
// page, onto HEX0..HEX5 and reports page / sticky error / heartbeat on LEDR.
// Optional feature macro: STATUS_AUTOSCROLL_EN builds the dwell timer that
// auto-advances pages (frozen by scroll_hold); without it only the
// debounced next key changes the page.
module board_status_pager #(
    parameter int NUM_CHANNELS     = 16,
    parameter int DEBOUNCE_CYCLES  = 500_000,
    parameter int DWELL_CYCLES     = 100_000_000,
    parameter int HEARTBEAT_CYCLES = 25_000_000
) (
    input  logic                sys_clk,
    input  logic                ext_rst_n,
    board_status_pager_if.slave pins
);
    localparam int NUM_PAGES  = (NUM_CHANNELS + 2) / 3;
    localparam int PAGE_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int PAGE_SLOTS = 1 << PAGE_W;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam int HB_W       = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_MAX    = HB_W'(HEARTBEAT_CYCLES - 1);

    // Active-low 7-segment encoding, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ---------------- key synchronisers and debounce ----------------
    // Bit 0 = next key, bit 1 = clear key. The synchronisers reset to the
    // "pressed" level so a key held through reset never looks released.
    logic [1:0]      key_s1_q, key_s2_q;
    logic [DB_W-1:0] db_cnt_q [0:1];
    logic [DB_W-1:0] db_cnt_d [0:1];
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [1:0]      armed_q, armed_d;
    logic [1:0]      press_s;

    // Two-flop synchroniser for the raw push-buttons.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            key_s1_q <= 2'b00;
            key_s2_q <= 2'b00;
        end else begin
            key_s1_q <= {pins.key_clr_n, pins.key_next_n};
            key_s2_q <= key_s1_q;
        end
    end

    // Debounce: count while the synchronised level disagrees with the
    // accepted one; a key only fires once it has been seen released.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            db_lvl_d[k] = db_lvl_q[k];
            press_s[k]  = 1'b0;
            armed_d[k]  = armed_q[k] | key_s2_q[k];
            if (key_s2_q[k] != db_lvl_q[k]) begin
                if (db_cnt_q[k] == DB_MAX) begin
                    db_lvl_d[k] = key_s2_q[k];
                    press_s[k]  = ~key_s2_q[k] & armed_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end
    end

    // Debounce state registers; accepted levels start released.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            db_lvl_q    <= 2'b11;
            armed_q     <= 2'b00;
        end else begin
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            db_lvl_q    <= db_lvl_d;
            armed_q     <= armed_d;
        end
    end

    // ---------------- dwell timer (optional) ----------------
    logic dwell_exp_s;

`ifdef STATUS_AUTOSCROLL_EN
    localparam int                DW_W   = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0]   DW_MAX = DW_W'(DWELL_CYCLES - 1);

    logic            hold_s1_q, hold_s2_q;
    logic [DW_W-1:0] dwell_q, dwell_d;

    // Two-flop synchroniser for the scroll-hold switch.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            hold_s1_q <= 1'b0;
            hold_s2_q <= 1'b0;
        end else begin
            hold_s1_q <= pins.scroll_hold;
            hold_s2_q <= hold_s1_q;
        end
    end

    // Dwell counter: a key press restarts it; hold freezes it in place.
    always_comb begin
        dwell_exp_s = 1'b0;
        dwell_d     = dwell_q;
        if (press_s[0]) begin
            dwell_d = '0;
        end else if (!hold_s2_q) begin
            if (dwell_q == DW_MAX) begin
                dwell_exp_s = 1'b1;
                dwell_d     = '0;
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Dwell counter register.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    assign dwell_exp_s = 1'b0;
`endif

    // ---------------- page, error flag, heartbeat ----------------
    logic [PAGE_W-1:0] page_q, page_d;
    logic              err_q, err_d;
    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic              hb_q, hb_d;

    // Next page (one advance even if press and expiry coincide), sticky
    // error where a set beats a same-cycle clear, heartbeat toggle on wrap.
    always_comb begin
        if (press_s[0] | dwell_exp_s) begin
            if (page_q == LAST_PAGE) begin
                page_d = '0;
            end else begin
                page_d = page_q + PAGE_W'(1);
            end
        end else begin
            page_d = page_q;
        end

        if (pins.read_error) begin
            err_d = 1'b1;
        end else if (press_s[1]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (hb_cnt_q == HB_MAX) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
            hb_d     = hb_q;
        end
    end

    // Page, error and heartbeat registers.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            page_q   <= '0;
            err_q    <= 1'b0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            page_q   <= page_d;
            err_q    <= err_d;
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    // ---------------- display ----------------
    // Each slot carries {hi digit, lo digit}; slots past the last channel
    // (and pages beyond NUM_PAGES) are blank.
    logic [13:0] slot_s [0:PAGE_SLOTS*3-1];
    logic [41:0] cand_s [0:PAGE_SLOTS-1];
    logic [41:0] hex_q, hex_d;

    for (genvar p = 0; p < PAGE_SLOTS; p++) begin : g_page
        for (genvar k = 0; k < 3; k++) begin : g_slot
            if (3 * p + k < NUM_CHANNELS) begin : g_live
                assign slot_s[3*p+k] = {seg7(pins.phases[3*p+k][7:4]),
                                        seg7(pins.phases[3*p+k][3:0])};
            end else begin : g_blank
                assign slot_s[3*p+k] = 14'h3FFF;
            end
        end
        assign cand_s[p] = {slot_s[3*p+2], slot_s[3*p+1], slot_s[3*p]};
    end

    // Live (non-snapshotted) digits for the current page.
    always_comb begin
        hex_d = cand_s[page_q];
    end

    // Registered digits: one cycle from phases/page to the pins.
    always_ff @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            hex_q <= {42{1'b1}};
        end else begin
            hex_q <= hex_d;
        end
    end

    for (genvar d = 0; d < 6; d++) begin : g_hex_out
        assign pins.hex[d] = hex_q[7*d +: 7];
    end

    assign pins.ledr = {hb_q, err_q, 8'(page_q)};

endmodule

// File: tb/tb_board_status_pager.sv
module tb_board_status_pager;
    localparam int NCH = 8;
    localparam int DB  = 4;
    localparam int DW  = 16;
    localparam int HB  = 8;
    localparam int NP  = 3;

    typedef struct packed {
        logic [1:0]            pg;
        logic [NCH-1:0][7:0]   ph;
        logic [41:0]           exp_hex;
    } vec_t;

    typedef struct packed {
        logic [41:0] hex;
        logic [8:0]  low_ledr;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic ext_rst_n = 1'b0;

    board_status_pager_if #(.NUM_CHANNELS(NCH)) pins ();

    board_status_pager #(
        .NUM_CHANNELS    (NCH),
        .DEBOUNCE_CYCLES (DB),
        .DWELL_CYCLES    (DW),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .sys_clk  (sys_clk),
        .ext_rst_n(ext_rst_n),
        .pins     (pins)
    );

    always #5 sys_clk = ~sys_clk;

    // Edges since reset release, used for the expected heartbeat.
    int unsigned cyc;
    always @(posedge sys_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_page = 0;
    logic exp_err = 1'b0;
    logic [NCH-1:0][7:0] tb_ph;
    vec_t vecs [5];
    exp_t sb_q [$];
    exp_t sb_e;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] model_hex(input logic [NCH-1:0][7:0] ph, input int pg);
        logic [41:0] h;
        h = {42{1'b1}};
        for (int k = 0; k < 3; k++) begin
            int c;
            c = 3 * pg + k;
            if (c < NCH) begin
                h[14*k +: 7]     = seg(ph[c][3:0]);
                h[14*k + 7 +: 7] = seg(ph[c][7:4]);
            end
        end
        return h;
    endfunction

    function automatic logic [41:0] dut_hex();
        logic [41:0] h;
        for (int d = 0; d < 6; d++) h[7*d +: 7] = pins.hex[d];
        return h;
    endfunction

    function automatic logic hb_exp();
        return 1'((cyc / HB) % 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic set_phases();
        for (int i = 0; i < NCH; i++) pins.phases[i] = tb_ph[i];
    endtask

    task automatic chk_ledr(input string name);
        chk(name, 64'(pins.ledr), 64'({hb_exp(), exp_err, 8'(exp_page)}));
    endtask

    task automatic chk_hex(input string name);
        chk(name, 64'(dut_hex()), 64'(model_hex(tb_ph, exp_page)));
    endtask

    // Press next for 10 cycles; page must move exactly 6 cycles after the fall.
    task automatic next_page();
        pins.key_next_n = 1'b0;
        tick(5);
        chk_ledr("next_before_latency");
        tick(1);
        exp_page = (exp_page + 1) % NP;
        chk_ledr("next_at_latency");
        tick(4);
        pins.key_next_n = 1'b1;
        tick(8);
    endtask

    initial begin
        pins.key_next_n  = 1'b1;
        pins.key_clr_n   = 1'b1;
        pins.scroll_hold = 1'b1;
        pins.read_error  = 1'b0;
        tb_ph = '0;
        tb_ph[0] = 8'h12; tb_ph[1] = 8'h34; tb_ph[2] = 8'h56;
        set_phases();

        // Table: target page, phases, expected digits.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < NCH; c++) vecs[r].ph[c] = 8'(8'h13 * (r + 1) + 8'h2B * c);
        end
        vecs[0].pg = 2'd0; vecs[1].pg = 2'd0; vecs[2].pg = 2'd1;
        vecs[3].pg = 2'd2; vecs[4].pg = 2'd0;
        vecs[1].ph[0] = 8'hAB; vecs[1].ph[1] = 8'hCD; vecs[1].ph[2] = 8'hEF;
        vecs[3].ph[6] = 8'h3C; vecs[3].ph[7] = 8'hE1;
        vecs[4].ph[0] = 8'h00; vecs[4].ph[1] = 8'hFF; vecs[4].ph[2] = 8'h5A;
        for (int r = 0; r < 5; r++) vecs[r].exp_hex = model_hex(vecs[r].ph, int'(vecs[r].pg));

        // Reset state.
        tick(3);
        chk("reset_hex", 64'(dut_hex()), 64'({42{1'b1}}));
        chk("reset_ledr", 64'(pins.ledr), 64'd0);

        // 1. Release reset, digits appear one cycle later.
        ext_rst_n = 1'b1;
        tick(1);
        chk_hex("release_hex");
        chk("hex1_digit1", 64'(pins.hex[1]), 64'(7'h79));
        chk("hex4_digit6", 64'(pins.hex[4]), 64'(7'h02));
        chk_ledr("release_ledr");

        // 2. Three-cycle bounce must be rejected, a real press accepted.
        pins.key_next_n = 1'b0;
        tick(3);
        pins.key_next_n = 1'b1;
        tick(12);
        chk_ledr("bounce_no_change");
        next_page();
        chk_hex("page1_hex");

        // 3. Page 2 shows channels 6,7 and a blank slot; next wraps to 0.
        next_page();
        chk_hex("page2_hex");
        chk("page2_hex4_blank", 64'(pins.hex[4]), 64'(7'h7F));
        chk("page2_hex5_blank", 64'(pins.hex[5]), 64'(7'h7F));
        next_page();
        chk_hex("wrap_page0_hex");

        // 5. Sticky error, clear press, and set-beats-clear.
        pins.read_error = 1'b1;
        tick(1);
        pins.read_error = 1'b0;
        exp_err = 1'b1;
        chk_ledr("err_set");
        tick(10);
        chk_ledr("err_held");
        pins.key_clr_n = 1'b0;
        tick(5);
        chk_ledr("clr_before_latency");
        tick(1);
        exp_err = 1'b0;
        chk_ledr("clr_at_latency");
        tick(4);
        pins.key_clr_n = 1'b1;
        tick(8);
        pins.key_clr_n = 1'b0;
        tick(5);
        pins.read_error = 1'b1;
        tick(1);
        exp_err = 1'b1;
        chk_ledr("set_wins_over_clr");
        pins.read_error = 1'b0;
        tick(4);
        pins.key_clr_n = 1'b1;
        tick(8);
        chk_ledr("set_wins_sticky");

        // Table-driven display vectors through the scoreboard.
        for (int r = 0; r < 5; r++) begin
            while (exp_page != int'(vecs[r].pg)) next_page();
            tb_ph = vecs[r].ph;
            set_phases();
            sb_q.push_back('{hex: vecs[r].exp_hex, low_ledr: {exp_err, 8'(exp_page)}});
            tick(1);
            sb_e = sb_q.pop_front();
            chk($sformatf("vec%0d_hex", r), 64'(dut_hex()), 64'(sb_e.hex));
            chk($sformatf("vec%0d_ledr", r), 64'(pins.ledr), 64'({hb_exp(), sb_e.low_ledr}));
        end

`ifdef STATUS_AUTOSCROLL_EN
        // 4. Dwell expiry, hold freezes and resumes, press on expiry.
        pins.scroll_hold = 1'b0;
        tick(17);
        chk_ledr("dwell_before_expiry");
        tick(1);
        exp_page = (exp_page + 1) % NP;
        chk_ledr("dwell_expiry");
        tick(1);
        pins.scroll_hold = 1'b1;
        tick(40);
        chk_ledr("hold_freezes");
        pins.scroll_hold = 1'b0;
        tick(14);
        chk_ledr("resume_before_expiry");
        tick(1);
        exp_page = (exp_page + 1) % NP;
        chk_ledr("resume_expiry");
        tick(10);
        pins.key_next_n = 1'b0;
        tick(5);
        chk_ledr("coincide_before");
        tick(1);
        exp_page = (exp_page + 1) % NP;
        chk_ledr("coincide_single_advance");
        tick(4);
        pins.key_next_n = 1'b1;
        pins.scroll_hold = 1'b1;
        tick(10);
        chk_ledr("coincide_reload");
        pins.scroll_hold = 1'b0;
        tick(5);
`endif

        // 6. Asynchronous reset mid-operation, key held through reset.
        @(posedge sys_clk);
        #2;
        ext_rst_n = 1'b0;
        pins.key_next_n = 1'b0;
        pins.scroll_hold = 1'b1;
        #1;
        exp_page = 0;
        exp_err  = 1'b0;
        chk("async_reset_hex", 64'(dut_hex()), 64'({42{1'b1}}));
        chk("async_reset_ledr", 64'(pins.ledr), 64'd0);
        tick(2);
        ext_rst_n = 1'b1;
        tick(20);
        chk_ledr("held_key_no_event");
        pins.key_next_n = 1'b1;
        tick(8);
        next_page();

        // Heartbeat toggles every HB cycles regardless of other state.
        for (int i = 0; i < 17; i++) begin
            tick(1);
            chk("heartbeat", 64'(pins.ledr[9]), 64'(hb_exp()));
        end

`ifndef STATUS_AUTOSCROLL_EN
        pins.scroll_hold = 1'b0;
        tick(100);
        chk_ledr("no_autoscroll_idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
